hazard_ctrl: RTL

//  Pipeline sequencer for the 5-stage core. Drives stall/clear/flush of the IF_to_ID and ID_to_EX

---
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes, data-memory freezes
// and operand forwarding selects for the 5-stage core.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FLUSH_CYCLES   = 2,
    parameter int MEM_TIMEOUT    = 255,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
    input  logic                      ex_wen_i,
    input  logic                      ex_load_i,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_i,
    input  logic                      mem_wen_i,
    input  logic                      branch_taken_i,
    input  logic                      dmem_req_i,
    input  logic                      dmem_rvalid_i,
    output logic                      stall_if_o,
    output logic                      stall_id_o,
    output logic                      flush_id_o,
    output logic                      stall_ex_o,
    output logic                      clear_ex_o,
    output logic                      fwrd_opA_type1_o,
    output logic                      fwrd_opA_type2_o,
    output logic                      fwrd_opB_type1_o,
    output logic                      fwrd_opB_type2_o,
    output logic                      err_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o
);
    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;
    localparam logic [1:0] S_ERROR    = 2'd3;

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(MEM_TIMEOUT);
    localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [FW-1:0]        flush_cnt_q, flush_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic                 mem_busy, load_use, freeze, flush, lu_stall;
    logic                 a_t1, a_t2, b_t1, b_t2;

    assign mem_busy = dmem_req_i & ~dmem_rvalid_i;
    assign load_use = ex_load_i & ex_wen_i & (ex_rd_i != '0) &
                      ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        freeze      = 1'b0;
        flush       = 1'b0;
        lu_stall    = 1'b0;
        case (state_q)
            S_RUN: begin
                if (mem_busy) begin
                    freeze     = 1'b1;
                    wait_cnt_d = WW'(1);
                    state_d    = S_MEM_WAIT;
                end else if (branch_taken_i) begin
                    flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end
                end else if (load_use) begin
                    lu_stall = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d = S_RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_q == WAIT_MAX) state_d = S_ERROR;
                    else wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_FLUSH: begin
                // a memory stall pauses the flush sequence without abandoning it
                if (mem_busy) begin
                    freeze = 1'b1;
                end else begin
                    flush = 1'b1;
                    if (flush_cnt_q == FW'(1)) state_d = S_RUN;
                    else flush_cnt_d = flush_cnt_q - FW'(1);
                end
            end
            default: freeze = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            if ((freeze | lu_stall) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign a_t1 = (id_rs1_i != '0) & ex_wen_i & ~ex_load_i & (ex_rd_i == id_rs1_i);
    assign a_t2 = (id_rs1_i != '0) & mem_wen_i & (mem_rd_i == id_rs1_i) & ~a_t1;
    assign b_t1 = (id_rs2_i != '0) & ex_wen_i & ~ex_load_i & (ex_rd_i == id_rs2_i);
    assign b_t2 = (id_rs2_i != '0) & mem_wen_i & (mem_rd_i == id_rs2_i) & ~b_t1;

    // outputs are gated by rst_n so the pipeline sees no control activity while in reset
    assign stall_if_o = rst_n & (freeze | lu_stall);
    assign stall_id_o = rst_n & (freeze | lu_stall);
    assign stall_ex_o = rst_n & freeze;
    assign flush_id_o = rst_n & flush;
    assign clear_ex_o = rst_n & (flush | lu_stall);

    assign fwrd_opA_type1_o = rst_n & a_t1 & ~stall_ex_o & ~clear_ex_o;
    assign fwrd_opA_type2_o = rst_n & a_t2 & ~stall_ex_o & ~clear_ex_o;
    assign fwrd_opB_type1_o = rst_n & b_t1 & ~stall_ex_o & ~clear_ex_o;
    assign fwrd_opB_type2_o = rst_n & b_t2 & ~stall_ex_o & ~clear_ex_o;

    assign err_o       = rst_n & (state_q == S_ERROR);
    assign stall_cnt_o = stall_cnt_q;
endmodule
